fetch_unit: RTL and testbench

- Program-counter and fetch stage that drives the 7-bit address of the instruction ROM and captures the 8-bit instruction it returns.
- Presents each captured instruction and its PC to the downstream decode stage through a valid/ready handshake.
- Handles absolute and PC-relative branches signalled back from decode, and halts on a configurable halt opcode.
- Keeps a fetch counter for debug and performance visibility.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program-counter / fetch stage. Drives the instruction ROM address, captures
// the returned opcode into an instruction register and hands it to decode
// over a valid/ready handshake. Supports absolute and PC-relative branches
// from decode, halts on HALT_OP, and counts loads for debug visibility.
module fetch_unit #(
  parameter logic [7:0] HALT_OP = 8'hFF,
  parameter int         COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic [6:0]         inst_addr_o,
  input  logic [7:0]         inst_data_i,
  output logic [7:0]         inst_o,
  output logic [6:0]         inst_pc_o,
  output logic               valid_o,
  input  logic               ready_i,
  input  logic               branch_i,
  input  logic               branch_rel_i,
  input  logic [7:0]         branch_val_i,
  output logic               halted_o,
  output logic [COUNT_W-1:0] fetch_count_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [6:0]           pc_q, pc_d;
  logic [7:0]           inst_q, inst_d;
  logic [6:0]           inst_pc_q, inst_pc_d;
  logic                 valid_q, valid_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic                 consume;
  logic                 load_en;
  logic                 br_take;
  logic                 halt_load;

  // Relative target: 7-bit PC plus sign-extended 8-bit offset, keep low 7 bits.
  function automatic logic [6:0] rel_target(input logic [6:0]        base,
                                            input logic signed [7:0] off);
    logic signed [7:0] sum;
    sum = $signed({1'b0, base}) + off;
    return sum[6:0];
  endfunction

  // Saturating increment so the counter sticks at all-ones.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (&v) return v;
    return v + {{(COUNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign consume   = valid_q && ready_i;
  assign load_en   = (state_q == RUN) && (!valid_q || ready_i);
  // A branch is only honoured while running and the current instruction leaves.
  assign br_take   = (state_q == RUN) && consume && branch_i;
  // A halt opcode captured without a competing branch stops fetching.
  assign halt_load = load_en && !br_take && (inst_data_i == HALT_OP);

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: IDLE waits for start, RUN stops on an accepted halt load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)   state_d = RUN;
      RUN:     if (halt_load) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: branch redirect beats load; HALT only drains valid.
  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    count_d   = count_q;
    if (br_take) begin
      // ROM data this cycle belongs to the wrong path: drop it, leave a bubble.
      pc_d    = branch_rel_i ? rel_target(inst_pc_q, $signed(branch_val_i))
                             : branch_val_i[6:0];
      valid_d = 1'b0;
    end else if (load_en) begin
      inst_d    = inst_data_i;
      inst_pc_d = pc_q;
      valid_d   = 1'b1;
      count_d   = sat_inc(count_q);
      // PC parks on the halt opcode so inst_addr_o shows where fetch stopped.
      if (inst_data_i != HALT_OP) pc_d = pc_q + 7'd1;
    end else if ((state_q == HALT) && consume) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers; everything returns to a known value on reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q      <= 7'd0;
      inst_q    <= 8'h00;
      inst_pc_q <= 7'd0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    inst_addr_o   = pc_q;
    inst_o        = inst_q;
    inst_pc_o     = inst_pc_q;
    valid_o       = valid_q;
    fetch_count_o = count_q;
    halted_o      = (state_q == HALT);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM array, rule-level reference model stepped on each
// rising edge, per-cycle comparison on the falling edge, plus literal checks.
module tb_fetch_unit;

  localparam int COUNT_W = 16;

  logic               clk;
  logic               reset_i, start_i, ready_i;
  logic               branch_i, branch_rel_i;
  logic [7:0]         branch_val_i;
  logic [6:0]         inst_addr_o;
  logic [7:0]         inst_data_i;
  logic [7:0]         inst_o;
  logic [6:0]         inst_pc_o;
  logic               valid_o, halted_o;
  logic [COUNT_W-1:0] fetch_count_o;

  logic [7:0] rom [128];

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Reference model state (0 = idle, 1 = running, 2 = halted).
  int         m_mode;
  logic [6:0] m_pc, m_ipc;
  logic [7:0] m_ir;
  logic       m_valid;
  int         m_cnt;

  fetch_unit #(.HALT_OP(8'hFF), .COUNT_W(COUNT_W)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .inst_addr_o(inst_addr_o), .inst_data_i(inst_data_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .valid_o(valid_o),
    .ready_i(ready_i), .branch_i(branch_i), .branch_rel_i(branch_rel_i),
    .branch_val_i(branch_val_i), .halted_o(halted_o),
    .fetch_count_o(fetch_count_o)
  );

  assign inst_data_i = rom[inst_addr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the fetch rules, applied to the inputs present at the edge.
  task automatic model_step();
    logic       cons;
    logic [7:0] d;
    if (reset_i) begin
      m_mode = 0; m_pc = 7'd0; m_ipc = 7'd0; m_ir = 8'h00; m_valid = 1'b0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (start_i) m_mode = 1;
    end else if (m_mode == 1) begin
      cons = m_valid && ready_i;
      if (cons && branch_i) begin
        if (branch_rel_i) m_pc = 7'((int'(m_ipc) + int'($signed(branch_val_i))) & 127);
        else              m_pc = branch_val_i[6:0];
        m_valid = 1'b0;
      end else if (!m_valid || ready_i) begin
        d       = rom[m_pc];
        m_ir    = d;
        m_ipc   = m_pc;
        m_valid = 1'b1;
        if (m_cnt < (1 << COUNT_W) - 1) m_cnt++;
        if (d == 8'hFF) m_mode = 2;
        else            m_pc = 7'((int'(m_pc) + 1) % 128);
      end
    end else begin
      if (m_valid && ready_i) m_valid = 1'b0;
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model addr",   32'(inst_addr_o),   32'(m_pc));
      chk("model inst",   32'(inst_o),        32'(m_ir));
      chk("model inst_pc",32'(inst_pc_o),     32'(m_ipc));
      chk("model valid",  32'(valid_o),       32'(m_valid));
      chk("model halted", 32'(halted_o),      32'(m_mode == 2));
      chk("model count",  32'(fetch_count_o), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " rst valid"},  32'(valid_o),       32'd0);
    chk({tag, " rst inst"},   32'(inst_o),        32'h00);
    chk({tag, " rst ipc"},    32'(inst_pc_o),     32'd0);
    chk({tag, " rst addr"},   32'(inst_addr_o),   32'd0);
    chk({tag, " rst count"},  32'(fetch_count_o), 32'd0);
    chk({tag, " rst halted"}, 32'(halted_o),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'hFF;
    for (int i = 0; i < 10; i++)  rom[i] = 8'(i);
    rom[7'h40] = 8'hA0;
    for (int i = 7'h75; i < 128; i++) rom[i] = 8'h50;

    reset_i = 1'b1; start_i = 1'b0; ready_i = 1'b0;
    branch_i = 1'b0; branch_rel_i = 1'b0; branch_val_i = 8'h00;
    cmp_en = 1'b1;
    step();
    chk_reset_vals("init");

    // Run B: stall, relative branch with wrap, PC wrap, absolute branches.
    reset_i = 1'b0; start_i = 1'b1; ready_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("B idle->run valid", 32'(valid_o), 32'd0);
    step_n(4);
    chk("B inst 03",  32'(inst_o), 32'h03);
    chk("B addr 04",  32'(inst_addr_o), 32'h04);
    chk("B count 4",  32'(fetch_count_o), 32'd4);
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("B stall inst",  32'(inst_o), 32'h03);
      chk("B stall addr",  32'(inst_addr_o), 32'h04);
      chk("B stall count", 32'(fetch_count_o), 32'd4);
    end
    ready_i = 1'b1;
    step();
    chk("B after stall inst", 32'(inst_o), 32'h04);
    step();
    chk("B ipc 05", 32'(inst_pc_o), 32'h05);
    branch_i = 1'b1; branch_rel_i = 1'b1; branch_val_i = 8'hF0;
    step();
    branch_i = 1'b0;
    chk("B rel bubble valid", 32'(valid_o), 32'd0);
    chk("B rel target addr",  32'(inst_addr_o), 32'h75);
    chk("B rel count",        32'(fetch_count_o), 32'd6);
    step();
    chk("B rel ipc 75",   32'(inst_pc_o), 32'h75);
    chk("B rel valid",    32'(valid_o), 32'd1);
    step_n(10);
    chk("B ipc 7F", 32'(inst_pc_o), 32'h7F);
    step();
    chk("B wrap ipc 00", 32'(inst_pc_o), 32'h00);
    step_n(2);
    chk("B inst 02", 32'(inst_o), 32'h02);
    branch_i = 1'b1; branch_rel_i = 1'b0; branch_val_i = 8'h40;
    step();
    branch_i = 1'b0;
    chk("B abs bubble valid", 32'(valid_o), 32'd0);
    chk("B abs addr 40",      32'(inst_addr_o), 32'h40);
    step();
    chk("B abs ipc 40",  32'(inst_pc_o), 32'h40);
    chk("B abs inst A0", 32'(inst_o), 32'hA0);
    chk("B abs valid",   32'(valid_o), 32'd1);
    // Address 41 holds the halt opcode; the branch must win over it.
    branch_i = 1'b1; branch_rel_i = 1'b0; branch_val_i = 8'h07;
    step();
    branch_i = 1'b0;
    chk("B br-over-halt halted", 32'(halted_o), 32'd0);
    chk("B br-over-halt valid",  32'(valid_o), 32'd0);
    chk("B br-over-halt addr",   32'(inst_addr_o), 32'h07);
    step();
    chk("B inst 07", 32'(inst_o), 32'h07);
    ready_i = 1'b0;
    step();
    chk("B stall inst 07", 32'(inst_o), 32'h07);
    reset_i = 1'b1; branch_i = 1'b1; branch_val_i = 8'h33; ready_i = 1'b1;
    step();
    chk_reset_vals("B midstall");
    reset_i = 1'b0; branch_i = 1'b0;
    step();
    chk("B idle valid", 32'(valid_o), 32'd0);
    chk("B idle addr",  32'(inst_addr_o), 32'd0);

    // Run A: straight line to the halt opcode at 0x0A.
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step_n(10);
    chk("A inst 09",   32'(inst_o), 32'h09);
    chk("A count 10",  32'(fetch_count_o), 32'd10);
    chk("A addr 0A",   32'(inst_addr_o), 32'h0A);
    step();
    chk("A halt inst",   32'(inst_o), 32'hFF);
    chk("A halt valid",  32'(valid_o), 32'd1);
    chk("A halted",      32'(halted_o), 32'd1);
    chk("A halt addr",   32'(inst_addr_o), 32'h0A);
    chk("A halt count",  32'(fetch_count_o), 32'd11);
    step();
    chk("A drained valid", 32'(valid_o), 32'd0);
    chk("A still halted",  32'(halted_o), 32'd1);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("A start ignored halted", 32'(halted_o), 32'd1);
    chk("A start ignored valid",  32'(valid_o), 32'd0);
    chk("A start ignored addr",   32'(inst_addr_o), 32'h0A);
    reset_i = 1'b1; branch_i = 1'b1; branch_val_i = 8'h20;
    step();
    chk_reset_vals("A halt");
    reset_i = 1'b0; branch_i = 1'b0;
    step();
    chk("A idle halted", 32'(halted_o), 32'd0);
    chk("A idle valid",  32'(valid_o), 32'd0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
